// File: rtl/gnr_step_ctrl.sv
// Step sequencer for a bank of two-phase GNR nodes: load, N x (s0, s1, settle), capture.
// Optional fixed-point early exit is compiled in with `define GNR_FIXPT_DETECT_EN.
module gnr_step_ctrl #(
  parameter int unsigned NUM_NODES = 8,
  parameter int unsigned STEP_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_NODES-1:0] init_vec,
  input  logic [STEP_W-1:0]    num_steps,
  input  logic [NUM_NODES-1:0] node_s1,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  output logic                 busy,
  output logic                 done,
  output logic [STEP_W-1:0]    steps_done,
  output logic [NUM_NODES-1:0] final_state,
  output logic                 fixpt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_PH0, S_PH1, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic                 r_reset_nos, r_start_s0, r_start_s1, r_busy, r_done;
  logic [NUM_NODES-1:0] r_init_state, r_final_state;
  logic [STEP_W-1:0]    r_num_steps, r_steps_done;
`ifdef GNR_FIXPT_DETECT_EN
  logic [NUM_NODES-1:0] r_prev_s1;
  logic                 r_fixpt;
  logic                 w_early;
`endif

  always_comb begin
    w_next = r_state;
`ifdef GNR_FIXPT_DETECT_EN
    w_early = 1'b0;
`endif
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   w_next = S_SETTLE;
      S_SETTLE: begin
        if (r_steps_done == r_num_steps) w_next = S_DONE;
`ifdef GNR_FIXPT_DETECT_EN
        else if (r_steps_done != '0 && node_s1 == r_prev_s1) begin
          w_next  = S_DONE;
          w_early = 1'b1;
        end
`endif
        else w_next = S_PH0;
      end
      S_PH0:    w_next = S_PH1;
      S_PH1:    w_next = S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) begin
      w_next = S_IDLE;
`ifdef GNR_FIXPT_DETECT_EN
      w_early = 1'b0;
`endif
    end
  end

  // Strobes are registered from the next state so they line up exactly with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_reset_nos   <= 1'b0;
      r_start_s0    <= 1'b0;
      r_start_s1    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_init_state  <= '0;
      r_num_steps   <= '0;
      r_steps_done  <= '0;
      r_final_state <= '0;
    end else begin
      r_state     <= w_next;
      r_reset_nos <= (w_next == S_LOAD);
      r_start_s0  <= (w_next == S_PH0);
      r_start_s1  <= (w_next == S_PH1);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      if (r_state == S_IDLE && start) begin
        r_init_state <= init_vec;
        r_num_steps  <= num_steps;
        r_steps_done <= '0;
      end
      // The s1 strobe already went out this cycle, so the step counts even if aborted.
      if (r_state == S_PH1) r_steps_done <= r_steps_done + STEP_W'(1);
      if (r_state == S_DONE && !abort) r_final_state <= node_s1;
    end
  end

`ifdef GNR_FIXPT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_s1 <= '0;
      r_fixpt   <= 1'b0;
    end else begin
      if (r_state == S_PH1) r_prev_s1 <= node_s1;
      if (r_state == S_IDLE && start) r_fixpt <= 1'b0;
      else if (w_early) r_fixpt <= 1'b1;
    end
  end
  assign fixpt = r_fixpt;
`else
  assign fixpt = 1'b0;
`endif

  assign reset_nos   = r_reset_nos;
  assign start_s0    = r_start_s0;
  assign start_s1    = r_start_s1;
  assign busy        = r_busy;
  assign done        = r_done;
  assign init_state  = r_init_state;
  assign steps_done  = r_steps_done;
  assign final_state = r_final_state;

endmodule

// File: tb/tb_gnr_step_ctrl.sv
// Directed bench for gnr_step_ctrl with a behavioural node bank (load on reset_nos, update on start_s1).
module tb_gnr_step_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  init_vec, node_s1, init_state, final_state;
  logic [15:0] num_steps, steps_done;
  logic        reset_nos, start_s0, start_s1, busy, done, fixpt;
  logic        node_mode;
  int          nvec = 0;
  int          nerr = 0;

  gnr_step_ctrl #(.NUM_NODES(8), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .init_vec(init_vec), .num_steps(num_steps), .node_s1(node_s1),
    .reset_nos(reset_nos), .init_state(init_state), .start_s0(start_s0),
    .start_s1(start_s1), .busy(busy), .done(done), .steps_done(steps_done),
    .final_state(final_state), .fixpt(fixpt)
  );

  always #5 clk = ~clk;

  // node_mode 0: each step increments; node_mode 1: every step lands on 8'h5A
  always @(posedge clk) begin
    if (rst) node_s1 <= 8'h00;
    else if (reset_nos) node_s1 <= init_state;
    else if (start_s1) node_s1 <= node_mode ? 8'h5A : node_s1 + 8'h01;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 idle, 1 reset_nos, 2 s0, 3 s1, 4 done, 7 more than one at once
  function automatic int code();
    int n = int'(reset_nos) + int'(start_s0) + int'(start_s1) + int'(done);
    if (n > 1) return 7;
    if (reset_nos) return 1;
    if (start_s0) return 2;
    if (start_s1) return 3;
    if (done) return 4;
    return 0;
  endfunction

  initial begin
    int seq_a [12] = '{1, 0, 2, 3, 0, 2, 3, 0, 2, 3, 0, 4};
    int seq_b [3]  = '{1, 0, 4};
    int ndone;
    int cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; node_mode = 1'b0;
    init_vec = 8'h00; num_steps = 16'd0;
    tick(); tick();
    chk("rst_strobes", 32'(code()), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init_state", 32'(init_state), 32'd0);
    chk("rst_steps_done", 32'(steps_done), 32'd0);
    chk("rst_final_state", 32'(final_state), 32'd0);
    chk("rst_fixpt", 32'(fixpt), 32'd0);
    rst = 1'b0;
    tick();

    // A: 3 steps from A5, with a start pulse mid-run that must be ignored
    init_vec = 8'hA5; num_steps = 16'd3; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 5) begin start = 1'b1; init_vec = 8'hFF; num_steps = 16'd7; end
      if (c == 6) start = 1'b0;
      chk($sformatf("A_seq%0d", c), 32'(code()), 32'(seq_a[c-1]));
      chk($sformatf("A_busy%0d", c), 32'(busy), 32'd1);
      chk($sformatf("A_init%0d", c), 32'(init_state), 32'hA5);
    end
    chk("A_steps_done", 32'(steps_done), 32'd3);
    tick();
    chk("A_idle_busy", 32'(busy), 32'd0);
    chk("A_idle_strobes", 32'(code()), 32'd0);
    chk("A_final_state", 32'(final_state), 32'hA8);

    // B: zero steps
    init_vec = 8'h3C; num_steps = 16'd0; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      chk($sformatf("B_seq%0d", c), 32'(code()), 32'(seq_b[c-1]));
    end
    chk("B_steps_done", 32'(steps_done), 32'd0);
    tick();
    chk("B_final_state", 32'(final_state), 32'h3C);
    chk("B_busy", 32'(busy), 32'd0);

    // C: abort during the 2nd PH1 of a 10-step run
    init_vec = 8'h01; num_steps = 16'd10; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    chk("C_in_ph1", 32'(code()), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("C_abort_busy", 32'(busy), 32'd0);
    chk("C_abort_strobes", 32'(code()), 32'd0);
    chk("C_steps_done", 32'(steps_done), 32'd2);
    chk("C_final_kept", 32'(final_state), 32'h3C);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) ndone++;
    end
    chk("C_no_done", 32'(ndone), 32'd0);
    chk("C_still_idle", 32'(busy), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("C_abort_in_idle", 32'(busy), 32'd0);

    // D: start held high across a 2-step run
    init_vec = 8'h10; num_steps = 16'd2; start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (done) ndone++;
      if (c == 9) chk("D_done_c9", 32'(done), 32'd1);
    end
    chk("D_one_done", 32'(ndone), 32'd1);
    chk("D_idle_busy", 32'(busy), 32'd0);
    chk("D_final_state", 32'(final_state), 32'h12);
    tick();
    chk("D_rerun_load", 32'(code()), 32'd1);
    chk("D_rerun_busy", 32'(busy), 32'd1);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("D_abort_busy", 32'(busy), 32'd0);
    chk("D_abort_steps", 32'(steps_done), 32'd0);

    // E: nodes settle at 5A after the first step
    node_mode = 1'b1;
    init_vec = 8'h11; num_steps = 16'd100; start = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (done) begin cyc = c; break; end
    end
`ifdef GNR_FIXPT_DETECT_EN
    chk("E_latency", 32'(cyc), 32'd9);
    chk("E_steps_done", 32'(steps_done), 32'd2);
    chk("E_fixpt", 32'(fixpt), 32'd1);
`else
    chk("E_latency", 32'(cyc), 32'd303);
    chk("E_steps_done", 32'(steps_done), 32'd100);
    chk("E_fixpt", 32'(fixpt), 32'd0);
`endif
    tick();
    chk("E_final_state", 32'(final_state), 32'h5A);
    tick();
`ifdef GNR_FIXPT_DETECT_EN
    chk("E_fixpt_held", 32'(fixpt), 32'd1);
`else
    chk("E_fixpt_held", 32'(fixpt), 32'd0);
`endif
    node_mode = 1'b0;
    init_vec = 8'h77; num_steps = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("E_fixpt_cleared", 32'(fixpt), 32'd0);
    chk("E_new_load", 32'(code()), 32'd1);

    // rst mid-run
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("R_strobes", 32'(code()), 32'd0);
    chk("R_busy", 32'(busy), 32'd0);
    chk("R_init_state", 32'(init_state), 32'd0);
    chk("R_final_state", 32'(final_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
